// File: rtl/axi_conf_pkg.sv
// Shared types and constants for the AXI configuration register block.
// The optional byte-strobe feature is selected with AXI_CONF_WSTRB_EN.
package axi_conf_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int BUSY_BIT = 0;
   localparam int DONE_BIT = 1;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      BUSY
   } state_t;

   typedef struct packed {
      logic        is_cfg;
      logic        is_stat;
      logic [29:0] idx;
   } dec_t;

   // Byte-lane merge of a new write value into the current register value.
   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_lite_wr_join.sv
// Joins independently arriving AW and W beats into a single write strobe
// and sequences the B response; at most one write is in flight.
module axi_lite_wr_join
   import axi_conf_pkg::*;
#(
   parameter int ID_W = 12
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     aw_addr,
   input  logic [ID_W-1:0] aw_id,
   input  logic            aw_valid,
   output logic            aw_ready,
   input  logic [31:0]     w_data,
   input  logic [3:0]      w_strb,
   input  logic            w_valid,
   output logic            w_ready,
   output logic [ID_W-1:0] b_id,
   output logic [1:0]      b_resp,
   output logic            b_valid,
   input  logic            b_ready,
   output logic            wr_exec,
   output logic [31:0]     wr_addr,
   output logic [31:0]     wr_data,
   output logic [3:0]      wr_strb,
   input  logic [1:0]      wr_resp
);

   logic            aw_held;
   logic            w_held;
   logic [ID_W-1:0] aw_id_q;

   assign aw_ready = !aw_held;
   assign w_ready  = !w_held;
   // Readies stay low until the B handshake, so a held pair executes exactly once.
   assign wr_exec  = aw_held && w_held && !b_valid;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_id_q <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_strb <= '0;
         b_valid <= 1'b0;
         b_id    <= '0;
         b_resp  <= RESP_OKAY;
      end else begin
         if (aw_valid && aw_ready) begin
            aw_held <= 1'b1;
            wr_addr <= aw_addr;
            aw_id_q <= aw_id;
         end
         if (w_valid && w_ready) begin
            w_held  <= 1'b1;
            wr_data <= w_data;
            wr_strb <= w_strb;
         end
         if (wr_exec) begin
            b_valid <= 1'b1;
            b_id    <= aw_id_q;
            b_resp  <= wr_resp;
         end else if (b_valid && b_ready) begin
            b_valid <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/axi_conf_regs.sv
// AXI slave config register file with W1C status and start/busy/done handshake.
// Define AXI_CONF_WSTRB_EN to honour WSTRB on config-register writes.
module axi_conf_regs
   import axi_conf_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'hA0000000,
   parameter int          NREG      = 4,
   parameter int          ID_W      = 12,
   parameter logic [31:0] CMD_RESET = 32'd0
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic [31:0]        S_AXI_AWADDR,
   input  logic [ID_W-1:0]    S_AXI_AWID,
   input  logic               S_AXI_AWVALID,
   output logic               S_AXI_AWREADY,
   input  logic [31:0]        S_AXI_WDATA,
   input  logic [3:0]         S_AXI_WSTRB,
   input  logic               S_AXI_WVALID,
   output logic               S_AXI_WREADY,
   output logic [ID_W-1:0]    S_AXI_BID,
   output logic [1:0]         S_AXI_BRESP,
   output logic               S_AXI_BVALID,
   input  logic               S_AXI_BREADY,
   input  logic [31:0]        S_AXI_ARADDR,
   input  logic [ID_W-1:0]    S_AXI_ARID,
   input  logic               S_AXI_ARVALID,
   output logic               S_AXI_ARREADY,
   output logic [31:0]        S_AXI_RDATA,
   output logic [ID_W-1:0]    S_AXI_RID,
   output logic [1:0]         S_AXI_RRESP,
   output logic               S_AXI_RLAST,
   output logic               S_AXI_RVALID,
   input  logic               S_AXI_RREADY,
   output logic [NREG*32-1:0] CFG_DATA,
   output logic               CFG_VALID,
   input  logic               CFG_READY,
   output logic               CFG_RESET,
   input  logic               CFG_DONE,
   output logic               CFG_IRQ
);

   localparam int IDX_W = $clog2(NREG);

   function automatic dec_t decode(input logic [31:0] addr);
      logic [31:0] off;
      dec_t        d;
      off       = addr - ADDR_BASE;
      d.idx     = off[31:2];
      d.is_cfg  = (off[1:0] == 2'b00) && (off[31:2] <  30'(NREG));
      d.is_stat = (off[1:0] == 2'b00) && (off[31:2] == 30'(NREG));
      return d;
   endfunction

   logic             wr_exec;
   logic [31:0]      wr_addr;
   logic [31:0]      wr_data;
   logic [3:0]       wr_strb;
   logic [1:0]       wr_resp;
   dec_t             wr_dec;
   dec_t             rd_dec;
   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] r_idx;
   logic [31:0]      wr_val;
   logic             cmd_lane;
   logic             unused_bits;

   logic [31:0] cfg_q [NREG];
   state_t      state_q;
   state_t      state_d;
   logic        busy;
   logic        done_q;
   logic        cfg_reset_q;

   logic        cfg_wr_ok;
   logic        cmd_hit;
   logic        cmd_start;
   logic        cmd_reset;
   logic        done_set;
   logic        done_clr;

   logic              rvalid_q;
   logic [31:0]       rdata_q;
   logic [ID_W-1:0]   rid_q;
   logic [1:0]        rresp_q;
   logic [31:0]       rd_val;
   logic [1:0]        rd_resp;
   logic              ar_accept;

   axi_lite_wr_join #(.ID_W(ID_W)) u_wr_join (
      .clk      (CLK),
      .reset    (reset),
      .aw_addr  (S_AXI_AWADDR),
      .aw_id    (S_AXI_AWID),
      .aw_valid (S_AXI_AWVALID),
      .aw_ready (S_AXI_AWREADY),
      .w_data   (S_AXI_WDATA),
      .w_strb   (S_AXI_WSTRB),
      .w_valid  (S_AXI_WVALID),
      .w_ready  (S_AXI_WREADY),
      .b_id     (S_AXI_BID),
      .b_resp   (S_AXI_BRESP),
      .b_valid  (S_AXI_BVALID),
      .b_ready  (S_AXI_BREADY),
      .wr_exec  (wr_exec),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_strb  (wr_strb),
      .wr_resp  (wr_resp)
   );

   assign wr_dec = decode(wr_addr);
   assign rd_dec = decode(S_AXI_ARADDR);
   assign w_idx  = wr_dec.idx[IDX_W-1:0];
   assign r_idx  = rd_dec.idx[IDX_W-1:0];
   assign busy   = (state_q != IDLE);

`ifdef AXI_CONF_WSTRB_EN
   assign wr_val      = apply_strb(cfg_q[w_idx], wr_data, wr_strb);
   assign cmd_lane    = wr_strb[0];
   assign unused_bits = ^{wr_dec.idx[29:IDX_W], rd_dec.idx[29:IDX_W]};
`else
   assign wr_val      = wr_data;
   assign cmd_lane    = 1'b1;
   assign unused_bits = ^{wr_dec.idx[29:IDX_W], rd_dec.idx[29:IDX_W], wr_strb};
`endif

   // Config registers are frozen outside IDLE so CFG_DATA is stable during a job.
   assign cfg_wr_ok = wr_exec && wr_dec.is_cfg && (state_q == IDLE);
   assign cmd_hit   = cfg_wr_ok && (w_idx == '0) && cmd_lane;
   assign cmd_start = cmd_hit && (wr_val != CMD_RESET);
   assign cmd_reset = cmd_hit && (wr_val == CMD_RESET);
   assign done_set  = (state_q == BUSY) && CFG_DONE;
   assign done_clr  = wr_exec && wr_dec.is_stat && wr_data[DONE_BIT];

   always_comb begin
      wr_resp = RESP_SLVERR;
      if (wr_dec.is_cfg) wr_resp = (state_q == IDLE) ? RESP_OKAY : RESP_SLVERR;
      else if (wr_dec.is_stat) wr_resp = RESP_OKAY;
   end

   // NOTE: the register array is small and must read as zero after reset, so
   // every entry is reset explicitly rather than left to a RAM macro.
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) cfg_q[i] <= '0;
      end else if (cfg_wr_ok) begin
         cfg_q[w_idx] <= wr_val;
      end
   end

   for (genvar i = 0; i < NREG; i++) begin : g_cfg_data
      assign CFG_DATA[32*i +: 32] = cfg_q[i];
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         cfg_reset_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_reset_q <= cmd_reset;
         if (done_set)      done_q <= 1'b1;
         else if (done_clr) done_q <= 1'b0;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      CFG_VALID = 1'b0;
      case (state_q)
         IDLE: if (cmd_start) state_d = PEND;
         PEND: begin
            CFG_VALID = 1'b1;
            if (CFG_READY) state_d = BUSY;
         end
         BUSY:    if (CFG_DONE) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign CFG_RESET = cfg_reset_q;
   assign CFG_IRQ   = done_q;

   always_comb begin
      rd_val  = '0;
      rd_resp = RESP_SLVERR;
      if (rd_dec.is_cfg) begin
         rd_val  = cfg_q[r_idx];
         rd_resp = RESP_OKAY;
      end else if (rd_dec.is_stat) begin
         rd_val[BUSY_BIT] = busy;
         rd_val[DONE_BIT] = done_q;
         rd_resp          = RESP_OKAY;
      end
   end

   assign S_AXI_ARREADY = !rvalid_q;
   assign ar_accept     = S_AXI_ARVALID && !rvalid_q;

   always_ff @(posedge CLK) begin
      if (reset) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_accept) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_val;
         rid_q    <= S_AXI_ARID;
         rresp_q  <= rd_resp;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RID    = rid_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RLAST  = rvalid_q;

endmodule
